axi_addr_arbiter: RTL and testbench

AXI_ADDR_ARBITER -- requirements
Module: axi_addr_arbiter

---
 rtl/axi_addr_arbiter.sv | 120 ++++++++++++
 tb/tb_axi_addr_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axi_addr_arbiter.sv
// rtl/axi_addr_arbiter.sv - M_CNT-to-1 AXI address request arbiter with a registered output stage
// Macro AXI_ARB_RR_EN selects round-robin arbitration; fixed priority (lowest index wins) otherwise.
module axi_addr_arbiter #(
    parameter int M_CNT = 4,
    parameter int DW    = 49
) (
    input  logic                AXI_CLK_i,
    input  logic                AXI_RST_i,
    input  logic [M_CNT-1:0]    REQ_VALID_i,
    input  logic [M_CNT*DW-1:0] REQ_DATA_i,
    output logic [M_CNT-1:0]    POP_o,
    output logic [M_CNT-1:0]    GRANT_o,
    output logic [7:0]          S_ID_o,
    output logic [31:0]         S_ADDR_o,
    output logic [3:0]          S_LEN_o,
    output logic [2:0]          S_SIZE_o,
    output logic [1:0]          S_BURST_o,
    output logic                S_VALID_o,
    input  logic                S_READY_i
);
    localparam int PW = $clog2(M_CNT);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_data;
    logic [M_CNT-1:0] r_grant;
    logic [PW-1:0]    w_win;
    logic             w_ld;
    logic [M_CNT-1:0] w_onehot;
    logic [DW-1:0]    w_win_data;

`ifdef AXI_ARB_RR_EN
    logic [PW-1:0]    r_ptr;

    // Search starts at the pointer and wraps, so the last winner gets lowest priority next time.
    always_comb begin
        int v_idx;
        logic v_found;
        v_idx   = 0;
        v_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < M_CNT; k++) begin
            v_idx = (int'(r_ptr) + k) % M_CNT;
            if (!v_found && REQ_VALID_i[v_idx]) begin
                v_found = 1'b1;
                w_win   = PW'(v_idx);
            end
        end
    end

    always_ff @(posedge AXI_CLK_i) begin
        if (AXI_RST_i) begin
            r_ptr <= '0;
        end else if (w_ld) begin
            r_ptr <= (w_win == PW'(M_CNT - 1)) ? '0 : w_win + 1'b1;
        end
    end
`else
    always_comb begin
        logic v_found;
        v_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < M_CNT; k++) begin
            if (!v_found && REQ_VALID_i[k]) begin
                v_found = 1'b1;
                w_win   = PW'(k);
            end
        end
    end
`endif

    // Reset gates the load so no FIFO is popped while the arbiter is being cleared.
    assign w_ld       = (|REQ_VALID_i) && ((r_state == ST_EMPTY) || S_READY_i) && !AXI_RST_i;
    assign w_onehot   = M_CNT'(1) << w_win;
    assign w_win_data = REQ_DATA_i[int'(w_win)*DW +: DW];
    assign POP_o      = w_ld ? w_onehot : '0;

    always_comb begin
        w_state_nxt = r_state;
        if (w_ld) begin
            w_state_nxt = ST_HOLD;
        end else if ((r_state == ST_HOLD) && S_READY_i) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge AXI_CLK_i) begin
        if (AXI_RST_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge AXI_CLK_i) begin
        if (AXI_RST_i) begin
            r_data  <= '0;
            r_grant <= '0;
        end else if (w_ld) begin
            r_data  <= w_win_data;
            r_grant <= w_onehot;
        end else if ((r_state == ST_HOLD) && S_READY_i) begin
            r_grant <= '0;
        end
    end

    assign S_VALID_o = (r_state == ST_HOLD);
    assign GRANT_o   = r_grant;
    assign S_ID_o    = r_data[48:41];
    assign S_ADDR_o  = r_data[40:9];
    assign S_LEN_o   = r_data[8:5];
    assign S_SIZE_o  = r_data[4:2];
    assign S_BURST_o = r_data[1:0];

endmodule

// File: tb/tb_axi_addr_arbiter.sv
// tb/tb_axi_addr_arbiter.sv - scoreboard bench for axi_addr_arbiter with a behavioural arbitration model
module tb_axi_addr_arbiter;
    localparam int M  = 4;
    localparam int DW = 49;

    logic            clk = 1'b0;
    logic            rst;
    logic [M-1:0]    req_valid;
    logic [M*DW-1:0] req_data;
    logic [M-1:0]    pop;
    logic [M-1:0]    grant;
    logic [7:0]      s_id;
    logic [31:0]     s_addr;
    logic [3:0]      s_len;
    logic [2:0]      s_size;
    logic [1:0]      s_burst;
    logic            s_valid;
    logic            s_ready;

    always #5 clk = ~clk;

    axi_addr_arbiter #(.M_CNT(M), .DW(DW)) dut (
        .AXI_CLK_i  (clk),
        .AXI_RST_i  (rst),
        .REQ_VALID_i(req_valid),
        .REQ_DATA_i (req_data),
        .POP_o      (pop),
        .GRANT_o    (grant),
        .S_ID_o     (s_id),
        .S_ADDR_o   (s_addr),
        .S_LEN_o    (s_len),
        .S_SIZE_o   (s_size),
        .S_BURST_o  (s_burst),
        .S_VALID_o  (s_valid),
        .S_READY_i  (s_ready)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0]   cur_data [M];
    logic            keep     [M];
    logic [M-1:0]    popped_last = '0;
    logic            m_valid     = 1'b0;
    logic            m_valid_nxt = 1'b0;
    int              m_ptr       = 0;
    logic [M-1:0]    exp_pop     = '0;
    logic [DW+M-1:0] expq[$];
    logic            mon_en      = 1'b0;

    // First requesting master at or after ptr, wrapping around; ptr stays 0 for fixed priority.
    function automatic int pick(input logic [M-1:0] v, input int ptr);
        for (int k = 0; k < M; k++) begin
            if (v[(ptr + k) % M]) return (ptr + k) % M;
        end
        return 0;
    endfunction

    task automatic set_data(input int m, input logic [7:0] id, input logic [31:0] addr);
        cur_data[m] = {id, addr, 4'h0, 3'h2, 2'h1};
        keep[m]     = 1'b1;
    endtask

    task automatic step(input logic [M-1:0] v, input logic rdy, input logic r);
        int w;
        m_valid = m_valid_nxt;
        for (int m = 0; m < M; m++) begin
            if (keep[m]) keep[m] = 1'b0;
            else if (!req_valid[m] || popped_last[m])
                cur_data[m] = {8'($urandom), $urandom, 4'($urandom), 3'($urandom), 2'($urandom)};
            req_data[m*DW +: DW] = cur_data[m];
        end
        req_valid = v;
        s_ready   = rdy;
        rst       = r;
        exp_pop   = '0;
        if (r) begin
            m_valid_nxt = 1'b0;
            m_ptr       = 0;
            expq.delete();
        end else if ((|v) && (!m_valid || rdy)) begin
            w          = pick(v, m_ptr);
            exp_pop[w] = 1'b1;
            expq.push_back({cur_data[w], exp_pop});
            m_valid_nxt = 1'b1;
`ifdef AXI_ARB_RR_EN
            m_ptr = (w + 1) % M;
`endif
        end else if (m_valid && rdy) begin
            m_valid_nxt = 1'b0;
        end
        popped_last = exp_pop;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            compared++;
            if (pop !== exp_pop) begin
                mismatched++;
                $display("FAIL pop_strobe t=%0t actual=%b required=%b", $time, pop, exp_pop);
            end
            compared++;
            if (s_valid !== m_valid) begin
                mismatched++;
                $display("FAIL s_valid t=%0t actual=%b required=%b", $time, s_valid, m_valid);
            end
            if (!m_valid) begin
                compared++;
                if (grant !== '0) begin
                    mismatched++;
                    $display("FAIL grant_empty t=%0t actual=%b required=0", $time, grant);
                end
            end else if (!rst) begin
                compared++;
                if (expq.size() == 0) begin
                    mismatched++;
                    $display("FAIL scoreboard_empty t=%0t actual=valid required=no_request", $time);
                end else begin
                    if ({s_id, s_addr, s_len, s_size, s_burst, grant} !== expq[0]) begin
                        mismatched++;
                        $display("FAIL held_request t=%0t actual=%h required=%h", $time,
                                 {s_id, s_addr, s_len, s_size, s_burst, grant}, expq[0]);
                    end
                    if (s_ready) void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        req_valid = '0;
        s_ready   = 1'b0;
        rst       = 1'b1;
        req_data  = '0;
        for (int m = 0; m < M; m++) begin
            keep[m]     = 1'b0;
            cur_data[m] = '0;
        end

        step(4'b0000, 1'b0, 1'b1);
        mon_en = 1'b1;
        compared++;
        if ({s_valid, grant, s_id, s_addr, s_len, s_size, s_burst} !== '0) begin
            mismatched++;
            $display("FAIL reset_state actual=%h required=0",
                     {s_valid, grant, s_id, s_addr, s_len, s_size, s_burst});
        end
        step(4'b0000, 1'b1, 1'b0);

        // Single request from master 0
        set_data(0, 8'h02, 32'h1000_0040);
        step(4'b0001, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        // Backpressure with all masters requesting
        step(4'b0100, 1'b1, 1'b0);
        repeat (5) step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        repeat (2) step(4'b0000, 1'b1, 1'b0);

        // Saturated requests from a fresh pointer
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b0);
        repeat (6) step(4'b1111, 1'b1, 1'b0);
        repeat (2) step(4'b0000, 1'b1, 1'b0);

        // Wrap from master 3 back to master 0
        step(4'b1000, 1'b1, 1'b0);
        repeat (2) step(4'b1001, 1'b1, 1'b0);
        repeat (2) step(4'b0000, 1'b1, 1'b0);

        // Two contenders, lowest index wins under fixed priority
        repeat (5) step(4'b0110, 1'b1, 1'b0);
        repeat (2) step(4'b0000, 1'b1, 1'b0);

        // Reset while holding a request
        repeat (2) step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b0);
        repeat (2) step(4'b0000, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step(M'($urandom) | (req_valid & ~popped_last), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 63) == 0));
        end
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
